// File: rtl/sdpram_rd_pkg.sv
// Shared types and sizing helpers for the SDP RAM burst read engine.
package sdpram_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic int fifo_depth(input int rd_latency);
    return rd_latency + 1;
  endfunction

  // Wide enough to hold the values 0..fifo_depth inclusive.
  function automatic int fifo_cnt_w(input int rd_latency);
    return $clog2(rd_latency + 2);
  endfunction

endpackage

// File: rtl/sdpram_burst_reader_if.sv
// Command and output-stream bundle of the burst read engine.
// Handshake: a beat moves on a cycle where valid && ready are both high; once
// valid rises, valid and its payload hold steady until that transfer.
interface sdpram_burst_reader_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 21,
  parameter int LEN_WIDTH  = 7
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, m_ready,
    output cmd_ready, m_valid, m_data, m_last
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, m_ready,
    input  cmd_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/sdpram_rd_skid_fifo.sv
// Small synchronous FIFO holding {last, data} words returned from the RAM.
module sdpram_rd_skid_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 22,
  parameter int CW    = 2
) (
  input  logic             clk,
  input  logic             rd_rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [CW-1:0]    count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Storage is cleared too so the head word reads as zero out of reset.
  always_ff @(posedge clk) begin
    if (!rd_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/sdpram_burst_reader.sv
// Burst read engine for the simple dual-port RAM read port, on rd_clk.
// Define SDPRAM_RD_BEAT_CNT_EN to add the beat_cnt / burst_done outputs.
module sdpram_burst_reader
  import sdpram_rd_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 21,
  parameter int LEN_WIDTH  = 7,
  parameter int RD_LATENCY = 1
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  sdpram_burst_reader_if.master bus,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  busy,
  output logic [1:0]            dbg_state
`ifdef SDPRAM_RD_BEAT_CNT_EN
  ,
  output logic [15:0]           beat_cnt,
  output logic                  burst_done
`endif
);
  localparam int DEPTH = fifo_depth(RD_LATENCY);
  localparam int CW    = fifo_cnt_w(RD_LATENCY);
  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(2 ** ADDR_WIDTH);
  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ISSUE = ISSUE;
  localparam logic [1:0] ST_DRAIN = DRAIN;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] cur_addr, last_addr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [RD_LATENCY-1:0] pipe_v, pipe_l;
  logic [CW-1:0]         fifo_count, inflight;
  logic [CW:0]           credit_used;
  logic                  issue, xfer, cmd_fire, fifo_empty, final_issue;
  logic [DATA_WIDTH:0]   fifo_dout;

  assign cmd_fire    = bus.cmd_valid && bus.cmd_ready;
  assign xfer        = bus.m_valid && bus.m_ready;
  assign final_issue = issue && (remaining == LEN_WIDTH'(1));

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CW'(pipe_v[i]);
  end

  // A slot freed by this cycle's pop counts as a credit so that a ready sink
  // sees one word per cycle; the FIFO still cannot overflow.
  assign credit_used = {1'b0, inflight} + {1'b0, fifo_count} - (CW+1)'(xfer);
  assign issue       = (state == ST_ISSUE) && (credit_used < (CW+1)'(DEPTH));
  assign mem_rd_addr = issue ? cur_addr : last_addr;

  assign bus.cmd_ready = (state == ST_IDLE);
  assign busy          = (state != ST_IDLE);
  assign dbg_state     = state;

  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      state     <= ST_IDLE;
      cur_addr  <= '0;
      last_addr <= '0;
      remaining <= '0;
      pipe_v    <= '0;
      pipe_l    <= '0;
    end else begin
      pipe_v <= RD_LATENCY'({pipe_v, issue});
      pipe_l <= RD_LATENCY'({pipe_l, final_issue});
      case (state)
        ST_IDLE: begin
          if (cmd_fire && (bus.cmd_len != '0)) begin
            cur_addr  <= bus.cmd_addr;
            remaining <= (bus.cmd_len > MAX_LEN) ? MAX_LEN : bus.cmd_len;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (issue) begin
            last_addr <= cur_addr;
            cur_addr  <= cur_addr + ADDR_WIDTH'(1);
            remaining <= remaining - LEN_WIDTH'(1);
            if (final_issue) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // The flagged word is the final one issued, so pipe and FIFO are empty after it.
          if (xfer && bus.m_last) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sdpram_rd_skid_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_WIDTH + 1),
    .CW    (CW)
  ) u_fifo (
    .clk      (rd_clk),
    .rd_rst_n (rd_rst_n),
    .push     (pipe_v[RD_LATENCY-1]),
    .pop      (xfer),
    .din      ({pipe_l[RD_LATENCY-1], mem_rd_data}),
    .dout     (fifo_dout),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign bus.m_valid = !fifo_empty;
  assign bus.m_last  = fifo_dout[DATA_WIDTH];
  assign bus.m_data  = fifo_dout[DATA_WIDTH-1:0];

`ifdef SDPRAM_RD_BEAT_CNT_EN
  always_ff @(posedge rd_clk) begin
    if (!rd_rst_n) begin
      beat_cnt   <= '0;
      burst_done <= 1'b0;
    end else begin
      burst_done <= xfer && bus.m_last;
      if (xfer && (beat_cnt != 16'hFFFF)) beat_cnt <= beat_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_sdpram_burst_reader.sv
// Bench: one engine with RD_LATENCY=1 and one with RD_LATENCY=2 driven in
// lockstep, each output stream scored against a burst-level reference model.
module tb_sdpram_burst_reader;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT wiring ----------------
  logic        cmd_valid;
  logic [5:0]  cmd_addr;
  logic [6:0]  cmd_len;
  logic        m_ready;

  logic [1:0]       cmd_ready, m_valid, m_last, busy;
  logic [1:0][20:0] m_data;
  logic [5:0]       mem_rd_addr0, mem_rd_addr1;
  logic [20:0]      mem_rd_data0, mem_rd_data1;
  logic [1:0]       dbg_state0, dbg_state1;
`ifdef SDPRAM_RD_BEAT_CNT_EN
  logic [15:0] beat_cnt0, beat_cnt1;
  logic        burst_done0, burst_done1;
`endif

  sdpram_burst_reader_if #(.ADDR_WIDTH(6), .DATA_WIDTH(21), .LEN_WIDTH(7)) bus0 ();
  sdpram_burst_reader_if #(.ADDR_WIDTH(6), .DATA_WIDTH(21), .LEN_WIDTH(7)) bus1 ();

  assign bus0.cmd_valid = cmd_valid;
  assign bus0.cmd_addr  = cmd_addr;
  assign bus0.cmd_len   = cmd_len;
  assign bus0.m_ready   = m_ready;
  assign bus1.cmd_valid = cmd_valid;
  assign bus1.cmd_addr  = cmd_addr;
  assign bus1.cmd_len   = cmd_len;
  assign bus1.m_ready   = m_ready;
  assign cmd_ready[0] = bus0.cmd_ready;
  assign cmd_ready[1] = bus1.cmd_ready;
  assign m_valid[0]   = bus0.m_valid;
  assign m_valid[1]   = bus1.m_valid;
  assign m_last[0]    = bus0.m_last;
  assign m_last[1]    = bus1.m_last;
  assign m_data[0]    = bus0.m_data;
  assign m_data[1]    = bus1.m_data;

  sdpram_burst_reader #(.ADDR_WIDTH(6), .DATA_WIDTH(21), .LEN_WIDTH(7), .RD_LATENCY(1)) u_dut1 (
    .rd_clk      (clk),
    .rd_rst_n    (rst_n),
    .bus         (bus0),
    .mem_rd_addr (mem_rd_addr0),
    .mem_rd_data (mem_rd_data0),
    .busy        (busy[0]),
    .dbg_state   (dbg_state0)
`ifdef SDPRAM_RD_BEAT_CNT_EN
    ,
    .beat_cnt    (beat_cnt0),
    .burst_done  (burst_done0)
`endif
  );

  sdpram_burst_reader #(.ADDR_WIDTH(6), .DATA_WIDTH(21), .LEN_WIDTH(7), .RD_LATENCY(2)) u_dut2 (
    .rd_clk      (clk),
    .rd_rst_n    (rst_n),
    .bus         (bus1),
    .mem_rd_addr (mem_rd_addr1),
    .mem_rd_data (mem_rd_data1),
    .busy        (busy[1]),
    .dbg_state   (dbg_state1)
`ifdef SDPRAM_RD_BEAT_CNT_EN
    ,
    .beat_cnt    (beat_cnt1),
    .burst_done  (burst_done1)
`endif
  );

  // ---------------- RAM models (no read enable) ----------------
  logic [20:0] ram [64];
  logic [20:0] rd1_q, rd2_a, rd2_b;
  initial for (int i = 0; i < 64; i++) ram[i] = 21'(i * 3);
  always @(posedge clk) rd1_q <= ram[mem_rd_addr0];
  always @(posedge clk) begin
    rd2_a <= ram[mem_rd_addr1];
    rd2_b <= rd2_a;
  end
  assign mem_rd_data0 = rd1_q;
  assign mem_rd_data1 = rd2_b;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [21:0] exp_q0[$];
  logic [21:0] exp_q1[$];
  int          beats [2];
  logic        stall_prev [2];
  logic [21:0] prev_word [2];
  int          rdy_mode = 0;
  int          pat = 0;
  int          done_cnt0 = 0;
  int          done_cnt1 = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a burst is a list of consecutive addresses mod 64,
  // length clamped to 64, with last set on the final one.
  task automatic model_burst(input int a, input int l);
    int eff;
    int idx;
    logic [21:0] w;
    eff = (l > 64) ? 64 : l;
    for (int k = 0; k < eff; k++) begin
      idx = (a + k) % 64;
      w = {(k == eff - 1), 21'(idx * 3)};
      exp_q0.push_back(w);
      exp_q1.push_back(w);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input int a, input int l);
    int n;
    n = 0;
    @(negedge clk);
    while (!(cmd_ready[0] && cmd_ready[1]) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL cmd_wait actual=busy expected=idle within 3000 cycles");
    end
    cmd_addr  = 6'(a);
    cmd_len   = 7'(l);
    cmd_valid = 1'b1;
    model_burst(a, l);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy != 2'b00 || exp_q0.size() != 0 || exp_q1.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=busy=%b q0=%0d q1=%0d expected=idle", busy, exp_q0.size(), exp_q1.size());
    end
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (cycles) @(negedge clk);
    exp_q0.delete();
    exp_q1.delete();
    done_cnt0 = 0;
    done_cnt1 = 0;
    rst_n = 1'b1;
  endtask

  // m_ready changes just after the active edge only
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (pat % 3 == 0);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      pat++;
    end
  end

  // ---------------- monitor ----------------
  task automatic mon(input int inst, input logic v, input logic r, input logic [20:0] d, input logic l);
    logic [21:0] got;
    logic [21:0] exp;
    logic        have;
    got = {l, d};
    if (!rst_n) begin
      stall_prev[inst] = 1'b0;
      return;
    end
    if (stall_prev[inst]) begin
      checks++;
      if (!v || got != prev_word[inst]) begin
        errors++;
        $display("FAIL stall_stable inst=%0d actual=v%0b %h expected=v1 %h", inst, v, got, prev_word[inst]);
      end
    end
    if (v && r) begin
      checks++;
      beats[inst]++;
      if (inst == 0) have = (exp_q0.size() != 0);
      else           have = (exp_q1.size() != 0);
      if (!have) begin
        errors++;
        $display("FAIL beat_extra inst=%0d actual=%h expected=no beat", inst, got);
      end else begin
        if (inst == 0) exp = exp_q0.pop_front();
        else           exp = exp_q1.pop_front();
        if (got != exp) begin
          errors++;
          $display("FAIL beat_data inst=%0d actual=%h expected=%h", inst, got, exp);
        end
      end
    end
    stall_prev[inst] = v && !r;
    prev_word[inst]  = got;
  endtask

  always @(negedge clk) mon(0, m_valid[0], m_ready, m_data[0], m_last[0]);
  always @(negedge clk) mon(1, m_valid[1], m_ready, m_data[1], m_last[1]);

  // FIFO occupancy bound of RD_LATENCY+1
  always @(negedge clk) begin
    if (rst_n) begin
      chk("fifo_bound_l1", (u_dut1.fifo_count > 2) ? 1 : 0, 0);
      chk("fifo_bound_l2", (u_dut2.fifo_count > 3) ? 1 : 0, 0);
    end
  end

`ifdef SDPRAM_RD_BEAT_CNT_EN
  always @(negedge clk) begin
    if (rst_n && burst_done0) done_cnt0++;
    if (rst_n && burst_done1) done_cnt1++;
  end
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int first_v [2];
  int last_v [2];
  int cnt_v [2];
  logic busy_at0 [16];
  int snap;

  initial begin
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    beats[0] = 0; beats[1] = 0;
    stall_prev[0] = 1'b0; stall_prev[1] = 1'b0;
    prev_word[0] = '0; prev_word[1] = '0;

    // reset values
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_cmd_ready", int'(cmd_ready[i]), 1);
      chk("rst_m_valid", int'(m_valid[i]), 0);
      chk("rst_m_last", int'(m_last[i]), 0);
      chk("rst_m_data", int'(m_data[i]), 0);
      chk("rst_busy", int'(busy[i]), 0);
    end
    chk("rst_rd_addr0", int'(mem_rd_addr0), 0);
    chk("rst_rd_addr1", int'(mem_rd_addr1), 0);
    rst_n = 1'b1;

    // addr 5 len 4, sink always ready: latency, back-to-back beats, busy fall
    rdy_mode = 0;
    send_cmd(5, 4);
    for (int i = 0; i < 2; i++) begin first_v[i] = -1; last_v[i] = -1; cnt_v[i] = 0; end
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      busy_at0[n] = busy[0];
      for (int i = 0; i < 2; i++) begin
        if (m_valid[i]) begin
          if (first_v[i] < 0) first_v[i] = n;
          last_v[i] = n;
          cnt_v[i]++;
        end
      end
    end
    chk("first_valid_l1", first_v[0], 3);
    chk("first_valid_l2", first_v[1], 4);
    chk("beat_count_l1", cnt_v[0], 4);
    chk("beat_count_l2", cnt_v[1], 4);
    chk("back_to_back_l1", last_v[0] - first_v[0], 3);
    chk("back_to_back_l2", last_v[1] - first_v[1], 3);
    if (last_v[0] >= 0 && last_v[0] < 15) chk("busy_fall_l1", int'(busy_at0[last_v[0] + 1]), 0);
    else chk("busy_fall_l1_window", last_v[0], 6);
    wait_idle(200);

    // address wrap 62,63,0,1
    send_cmd(62, 4);
    wait_idle(200);

    // backpressure pattern
    rdy_mode = 1;
    send_cmd(10, 8);
    wait_idle(400);

    // zero length then full depth
    rdy_mode = 0;
    send_cmd(7, 0);
    @(negedge clk);
    chk("len0_busy_l1", int'(busy[0]), 0);
    chk("len0_busy_l2", int'(busy[1]), 0);
    chk("len0_ready", int'(cmd_ready[0] && cmd_ready[1]), 1);
    chk("len0_no_valid", int'(m_valid[0] || m_valid[1]), 0);
    snap = beats[0];
    send_cmd(0, 64);
    wait_idle(400);
    chk("len64_beats", beats[0] - snap, 64);

    // clamp of oversize length
    rdy_mode = 2;
    snap = beats[1];
    send_cmd(33, 100);
    wait_idle(800);
    chk("clamp_beats", beats[1] - snap, 64);

    // randomized bursts
    for (int t = 0; t < 20; t++) begin
      rdy_mode = ($urandom_range(0, 3) == 0) ? 1 : 2;
      send_cmd($urandom_range(0, 63), ($urandom_range(0, 4) == 0) ? $urandom_range(0, 127) : $urandom_range(1, 12));
      if ($urandom_range(0, 1) == 0) wait_idle(800);
    end
    wait_idle(2000);

    // reset in the middle of a burst
    rdy_mode = 0;
    snap = beats[0];
    send_cmd(20, 10);
    for (int n = 0; n < 200 && beats[0] - snap < 3; n++) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("midrst_m_valid", int'(m_valid[i]), 0);
      chk("midrst_cmd_ready", int'(cmd_ready[i]), 1);
      chk("midrst_busy", int'(busy[i]), 0);
    end
    exp_q0.delete();
    exp_q1.delete();
    rst_n = 1'b1;
    snap = beats[0];
    send_cmd(0, 2);
    wait_idle(200);
    repeat (5) @(negedge clk);
    chk("post_rst_beats", beats[0] - snap, 2);

    // two bursts after a fresh reset
    apply_reset(2);
    send_cmd(40, 3);
    send_cmd(60, 5);
    wait_idle(300);
    repeat (3) @(negedge clk);
`ifdef SDPRAM_RD_BEAT_CNT_EN
    chk("beat_cnt_l1", int'(beat_cnt0), 8);
    chk("beat_cnt_l2", int'(beat_cnt1), 8);
    chk("burst_done_l1", done_cnt0, 2);
    chk("burst_done_l2", done_cnt1, 2);
`endif

    chk("final_q0_empty", exp_q0.size(), 0);
    chk("final_q1_empty", exp_q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdpram_burst_reader.md
Name: sdpram_burst_reader

Overview:
- Read-side engine for the 64-entry x 21-bit simple dual-port RAM macro.
- Accepts burst read commands (start address, length) and drives the RAM read-address port.
- Tracks the RAM's fixed read latency and presents returned words as a valid/ready stream with a last flag.
- Sits on the RAM's read clock domain, opposite the write-side producer.

Parameters:
- ADDR_WIDTH, 6, RAM address width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 21, RAM/stream data width.
- LEN_WIDTH, 7, burst length field width; legal lengths 0..2**ADDR_WIDTH.
- RD_LATENCY, 1, RAM read latency in cycles: 1 = no output register, 2 = output register on.

Ports:
- rd_clk  in  1  single clock, shared with the RAM read port.
- rd_rst_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  engine idle, command accepted this cycle when both high.
- cmd_addr  in  ADDR_WIDTH  burst start address.
- cmd_len  in  LEN_WIDTH  number of words to read.
- mem_rd_addr  out  ADDR_WIDTH  to RAM rd_addr.
- mem_rd_data  in  DATA_WIDTH  from RAM rd_data; valid RD_LATENCY cycles after the address.
- m_valid  out  1  stream data valid.
- m_ready  in  1  stream sink ready.
- m_data  out  DATA_WIDTH  stream data.
- m_last  out  1  final word of the burst.
- busy  out  1  burst in progress (command accepted, last beat not yet transferred).

Behaviour:
- Clock and reset: one clock, rd_clk; reset is synchronous and active-low (rd_rst_n sampled on the rd_clk rising edge).
- Reset values: cmd_ready=1, m_valid=0, m_last=0, m_data=0, busy=0, mem_rd_addr=0, all counters and the latency pipe cleared, FIFO emptied.
- Reset mid-burst: the burst is abandoned with no further beats. Words already in flight from the RAM are discarded.
- IDLE state:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready with cmd_len!=0: latch addr and len, go to ISSUE; busy=1 from the next cycle.
  - cmd_len==0: command consumed, no beats, stays IDLE.
  - cmd_len > 2**ADDR_WIDTH: clamped to 2**ADDR_WIDTH.
- ISSUE state:
  - Each cycle, an issue is allowed when credits are available: inflight + fifo_count < RD_LATENCY+1.
  - On an issue: present the current address on mem_rd_addr, push a 1 into the RD_LATENCY-deep valid pipe (with its last bit), then increment the address and decrement remaining.
  - Address wraps mod 2**ADDR_WIDTH (63 -> 0).
  - When the final word is issued, go to DRAIN.
  - When no issue happens, mem_rd_addr holds its value and a 0 is pushed into the pipe.
- Return path:
  - When the pipe tail is 1, capture mem_rd_data and the last bit into the output FIFO (depth RD_LATENCY+1).
  - The credit rule guarantees the FIFO never overflows. No backpressure reaches the RAM, because the RAM has no read enable.
- DRAIN state: when the pipe is empty, the FIFO is empty, and the last beat has transferred, go to IDLE; busy=0 and cmd_ready=1 on the next cycle.
- Stream rules:
  - m_valid/m_data/m_last come directly from the FIFO head.
  - Once m_valid is asserted, it and m_data/m_last stay stable until m_ready.
  - A transfer happens on m_valid&&m_ready.
- Latency: a command accepted at cycle 0 presents the first address at cycle 1; first m_valid at cycle 1+RD_LATENCY+1.
- Throughput: with m_ready held high, one word per cycle sustained.
- Simultaneous FIFO push and pop: both happen in the same cycle and fifo_count is unchanged.
- New commands: ignored (cmd_ready=0) until the engine returns to IDLE; no command overlap.

Optional Feature:
- Macro: SDPRAM_RD_BEAT_CNT_EN.
- When defined:
  - Adds output beat_cnt [15:0]: a saturating count of stream transfers since reset, holding at 16'hFFFF.
  - Adds output burst_done: a 1-cycle pulse on each m_last transfer.
- When undefined: the ports are absent and no logic is generated.

Decomposition:
- Package sdpram_rd_pkg:
  - state enum {IDLE, ISSUE, DRAIN};
  - localparam helpers for FIFO depth (RD_LATENCY+1) and its count width.
- Sub-module sdpram_rd_skid_fifo: a small parameterised synchronous FIFO (depth, width) holding {last,data}, with push/pop/count and the same rd_rst_n.

Test Plan:
- RAM preloaded with data=addr*3; cmd addr=5 len=4, m_ready=1 -> m_data 15,18,21,24 on consecutive cycles, m_last on 24, busy falls after it.
- Wrap: cmd addr=62 len=4 -> data from addresses 62,63,0,1; m_last on address 1.
- Backpressure: len=8, m_ready toggling 1,0,0,1,... -> no word lost or duplicated, data stable while stalled, FIFO count never exceeds RD_LATENCY+1 (check both RD_LATENCY=1 and 2).
- cmd_len=0 then len=64 addr=0 -> first command produces no beats; second produces 64 beats of addresses 0..63 with m_last only on the 64th.
- Reset mid-burst: rd_rst_n=0 at beat 3 of len=10 -> next cycle m_valid=0, cmd_ready=1, busy=0; a new cmd addr=0 len=2 returns exactly 2 correct beats.
- With SDPRAM_RD_BEAT_CNT_EN: two bursts of len 3 and len 5 -> beat_cnt=8, burst_done pulses exactly twice.
